// File: rtl/window_seq.sv
// Frame sequencer for the window -> FFT datapath: waits for a chirp, settles,
// waits for FFT ready, windows N samples, then checks that N outputs return.
module window_seq #(
   parameter int unsigned N               = 1024,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned SETTLE_WIDTH    = 16,
   parameter int unsigned FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clk_en,
   input  logic                       chirp_start,
   input  logic [SETTLE_WIDTH-1:0]    settle_len,
   input  logic                       fft_ready,
   input  logic                       abort,
   input  logic                       clr_status,
   input  logic                       win_dvalid,
   output logic                       win_en,
   output logic                       busy,
   output logic                       frame_done,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
   output logic                       overrun,
   output logic                       pipe_err
);

   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned DW = $clog2(LATENCY + 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_WAIT_RDY,
      S_ACTIVE,
      S_DRAIN
   } state_t;

   state_t                  state;
   logic                    pending;
   logic [SETTLE_WIDTH-1:0] settle_ctr;
   logic [CW-1:0]           samp_ctr;
   logic [CW-1:0]           out_ctr;
   logic [DW-1:0]           drain_ctr;

   logic accept_c;
   logic chirp_ovr_c;
   logic extra_dv_c;
   logic timeout_c;
   logic counting_c;

   // Event decode shared by the state register and the sticky flags
   always_comb begin
      accept_c    = (state == S_IDLE) && clk_en && pending;
      chirp_ovr_c = chirp_start && !abort && (busy || accept_c);
      extra_dv_c  = clk_en && win_dvalid && (out_ctr == CW'(N));
      timeout_c   = (state == S_DRAIN) && (out_ctr != CW'(N)) &&
                    (drain_ctr == DW'(LATENCY + 2));
      counting_c  = clk_en && win_dvalid && (out_ctr != CW'(N)) &&
                    ((state == S_ACTIVE) || (state == S_DRAIN));
   end

   // Sequencer state, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pending    <= 1'b0;
         settle_ctr <= '0;
         samp_ctr   <= '0;
         out_ctr    <= '0;
         drain_ctr  <= '0;
         win_en     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         overrun    <= 1'b0;
         pipe_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // Sticky flags: a new error in the same cycle beats a clear
         if (chirp_ovr_c)             overrun  <= 1'b1;
         else if (clr_status)         overrun  <= 1'b0;
         if (extra_dv_c || timeout_c) pipe_err <= 1'b1;
         else if (clr_status)         pipe_err <= 1'b0;

         if (abort) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            settle_ctr <= '0;
            samp_ctr   <= '0;
            out_ctr    <= '0;
            drain_ctr  <= '0;
            win_en     <= 1'b0;
            busy       <= 1'b0;
         end else begin
            // A chirp seen in the accept cycle is an overrun, not a queued frame
            if (chirp_start && !busy && !accept_c) pending <= 1'b1;
            else if (accept_c)                     pending <= 1'b0;

            if (counting_c) out_ctr <= out_ctr + CW'(1);

            unique case (state)
               S_IDLE: begin
                  if (accept_c) begin
                     settle_ctr <= settle_len;
                     busy       <= 1'b1;
                     state      <= (settle_len == '0) ? S_WAIT_RDY : S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (clk_en) begin
                     settle_ctr <= settle_ctr - SETTLE_WIDTH'(1);
                     if (settle_ctr == SETTLE_WIDTH'(1)) state <= S_WAIT_RDY;
                  end
               end
               S_WAIT_RDY: begin
                  if (clk_en && fft_ready) begin
                     win_en   <= 1'b1;
                     samp_ctr <= '0;
                     out_ctr  <= '0;
                     state    <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  if (clk_en) begin
                     samp_ctr <= samp_ctr + CW'(1);
                     if (samp_ctr == CW'(N - 1)) begin
                        win_en    <= 1'b0;
                        drain_ctr <= '0;
                        state     <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  if (out_ctr == CW'(N)) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + FRAME_CNT_WIDTH'(1);
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end else if (timeout_c) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else if (clk_en) begin
                     drain_ctr <= drain_ctr + DW'(1);
                  end
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_window_seq.sv
// Directed bench for window_seq with a LATENCY-deep window model in the loop.
module tb_window_seq;

   localparam int unsigned N   = 8;
   localparam int unsigned SW  = 16;
   localparam int unsigned FCW = 4;

   logic           clk;
   logic           rst_n;
   logic           clk_en;
   logic           chirp_start;
   logic [SW-1:0]  settle_len;
   logic           fft_ready;
   logic           abort;
   logic           clr_status;
   logic           win_dvalid;
   logic           win_en;
   logic           busy;
   logic           frame_done;
   logic [FCW-1:0] frame_cnt;
   logic           overrun;
   logic           pipe_err;

   logic       kill     = 1'b0;
   logic       force_dv = 1'b0;
   logic [1:0] wd;

   int n_checks = 0;
   int n_pass   = 0;
   int tick_no  = 0;
   int en_ticks = 0;
   int rise_tick = 0;
   int acc_tick = 0;
   int done_cnt = 0;
   bit armed    = 1'b0;
   bit en_prev  = 1'b0;

   window_seq #(
      .N(N), .LATENCY(2), .SETTLE_WIDTH(SW), .FRAME_CNT_WIDTH(FCW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .chirp_start(chirp_start),
      .settle_len(settle_len), .fft_ready(fft_ready), .abort(abort),
      .clr_status(clr_status), .win_dvalid(win_dvalid), .win_en(win_en),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .overrun(overrun), .pipe_err(pipe_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // clk_en every second clk
   initial begin
      clk_en = 1'b0;
      forever @(negedge clk) clk_en = ~clk_en;
   end

   // Window model: dvalid is en delayed by two clk_en ticks
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      wd <= 2'b00;
      else if (clk_en) wd <= {wd[0], win_en};
   end
   assign win_dvalid = (wd[1] & ~kill) | force_dv;

   // Tick bookkeeping: accept tick, first enabled tick, enabled tick count
   always @(posedge clk) begin
      if (clk_en) begin
         if (armed) begin
            acc_tick <= tick_no;
            armed    <= 1'b0;
         end
         if (win_en) en_ticks <= en_ticks + 1;
         if (win_en && !en_prev) rise_tick <= tick_no;
         en_prev <= win_en;
         tick_no <= tick_no + 1;
      end
      if (chirp_start && !busy && !abort) armed <= 1'b1;
   end

   always @(negedge clk) if (frame_done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic pulse_chirp();
      @(negedge clk) chirp_start = 1'b1;
      @(negedge clk) chirp_start = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_status = 1'b1;
      @(negedge clk) clr_status = 1'b0;
   endtask

   task automatic wait_busy(input string tag, input logic lvl);
      int k = 0;
      while (busy !== lvl && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (busy !== lvl) check(tag, int'(busy), int'(lvl));
   endtask

   task automatic wait_win(input string tag, input logic lvl);
      int k = 0;
      while (win_en !== lvl && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (win_en !== lvl) check(tag, int'(win_en), int'(lvl));
   endtask

   task automatic run_frame(input string tag);
      pulse_chirp();
      wait_busy({tag, "_start"}, 1'b1);
      wait_busy({tag, "_end"}, 1'b0);
   endtask

   initial begin
      int e0, d0, bad;
      rst_n = 1'b0; chirp_start = 1'b0; settle_len = SW'(3); fft_ready = 1'b1;
      abort = 1'b0; clr_status = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_win_en", int'(win_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_pipe_err", int'(pipe_err), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic frame
      e0 = en_ticks; d0 = done_cnt;
      run_frame("t1");
      repeat (4) @(negedge clk);
      check("t1_en_ticks", en_ticks - e0, 8);
      check("t1_en_offset", rise_tick - acc_tick - 1, 4);
      check("t1_done", done_cnt - d0, 1);
      check("t1_frame_cnt", int'(frame_cnt), 1);
      check("t1_pipe_err", int'(pipe_err), 0);

      // 2: FFT not ready for 20 ticks after settle
      fft_ready = 1'b0; e0 = en_ticks; d0 = done_cnt; bad = 0;
      pulse_chirp();
      wait_busy("t2_start", 1'b1);
      repeat (46) begin
         @(negedge clk);
         if (!busy || win_en) bad++;
      end
      check("t2_hold", bad, 0);
      fft_ready = 1'b1;
      wait_busy("t2_end", 1'b0);
      repeat (4) @(negedge clk);
      check("t2_en_ticks", en_ticks - e0, 8);
      check("t2_done", done_cnt - d0, 1);
      check("t2_frame_cnt", int'(frame_cnt), 2);

      // 3: second chirp during ACTIVE
      d0 = done_cnt;
      pulse_chirp();
      wait_win("t3_win", 1'b1);
      pulse_chirp();
      check("t3_overrun", int'(overrun), 1);
      wait_busy("t3_end", 1'b0);
      repeat (30) @(negedge clk);
      check("t3_busy", int'(busy), 0);
      check("t3_frame_cnt", int'(frame_cnt), 3);
      check("t3_done", done_cnt - d0, 1);
      pulse_clr();
      check("t3_clr", int'(overrun), 0);

      // 4: abort mid-frame, then abort racing a chirp, then a full frame
      d0 = done_cnt;
      pulse_chirp();
      wait_win("t4_win", 1'b1);
      repeat (8) @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("t4_win_en", int'(win_en), 0);
      check("t4_busy", int'(busy), 0);
      repeat (40) @(negedge clk);
      check("t4_frame_cnt", int'(frame_cnt), 3);
      check("t4_done", done_cnt - d0, 0);
      check("t4_pipe_err", int'(pipe_err), 0);
      @(negedge clk) begin abort = 1'b1; chirp_start = 1'b1; end
      @(negedge clk) begin abort = 1'b0; chirp_start = 1'b0; end
      repeat (20) @(negedge clk);
      check("t4_race_busy", int'(busy), 0);
      check("t4_race_overrun", int'(overrun), 0);
      e0 = en_ticks;
      run_frame("t4b");
      repeat (4) @(negedge clk);
      check("t4_new_en_ticks", en_ticks - e0, 8);
      check("t4_new_frame_cnt", int'(frame_cnt), 4);

      // 5: last two outputs missing -> drain timeout
      d0 = done_cnt;
      pulse_chirp();
      wait_win("t5_win_hi", 1'b1);
      wait_win("t5_win_lo", 1'b0);
      kill = 1'b1;
      wait_busy("t5_end", 1'b0);
      kill = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_pipe_err", int'(pipe_err), 1);
      check("t5_done", done_cnt - d0, 0);
      check("t5_frame_cnt", int'(frame_cnt), 4);
      pulse_clr();
      check("t5_clr", int'(pipe_err), 0);

      // Stray dvalid after a complete frame, coincident with clr_status
      run_frame("t5b");
      repeat (4) @(negedge clk);
      check("t5b_frame_cnt", int'(frame_cnt), 5);
      @(negedge clk);
      #1;
      if (!clk_en) begin
         @(negedge clk);
         #1;
      end
      force_dv = 1'b1; clr_status = 1'b1;
      @(negedge clk) begin force_dv = 1'b0; clr_status = 1'b0; end
      check("clr_vs_err", int'(pipe_err), 1);
      pulse_clr();
      check("clr_after_err", int'(pipe_err), 0);

      // 6: 17 back-to-back frames wrap the 4-bit counter
      settle_len = SW'(0); d0 = done_cnt;
      for (int i = 0; i < 17; i++) run_frame("t6");
      repeat (4) @(negedge clk);
      check("t6_frame_cnt", int'(frame_cnt), (5 + 17) % 16);
      check("t6_done", done_cnt - d0, 17);

      // Async reset mid-frame
      pulse_chirp();
      wait_win("t6_win", 1'b1);
      pulse_chirp();
      check("t6_pre_overrun", int'(overrun), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_win_en", int'(win_en), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_frame_cnt", int'(frame_cnt), 0);
      check("t6_rst_overrun", int'(overrun), 0);
      check("t6_rst_pipe_err", int'(pipe_err), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_post_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
